// File: rtl/imem_pkg.sv
// imem_pkg: shared types and address decode for the loadable instruction memory.
// Decode is written once here so the fetch and load ports cannot drift apart.
package imem_pkg;

  localparam int AW_MAX = 64;

  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10
  } flt_e;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    RUN   = 2'b01,
    LOAD  = 2'b10
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    flt_e              fault;
    logic [AW_MAX-1:0] idx;
  } dec_t;

  // Misalignment wins over range so a bad low pair is always reported first.
  function automatic dec_t decode(
    input logic [AW_MAX-1:0] addr,
    input int                idx_w
  );
    dec_t              d;
    logic [AW_MAX-1:0] mask;
    mask  = (AW_MAX'(1) << idx_w) - AW_MAX'(1);
    d.idx = (addr >> 2) & mask;
    if (addr[1:0] != 2'b00)
      d.fault = FLT_MISALIGN;
    else if ((addr >> (idx_w + 2)) != '0)
      d.fault = FLT_RANGE;
    else
      d.fault = FLT_OK;
    return d;
  endfunction

endpackage

// File: rtl/imem_if.sv
// imem_if: fetch request/response channels plus the program load port.
// master = fetch stage / boot master side, slave = memory side.
interface imem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              load_en;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_err;
  logic              busy;

  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr;

  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst;
  logic [1:0]        inst_fault;

  modport master (
    output load_en, ld_we, ld_addr, ld_data,
    output fetch_valid, fetch_addr, inst_ready,
    input  ld_err, busy, fetch_ready,
    input  inst_valid, inst, inst_fault
  );

  modport slave (
    input  load_en, ld_we, ld_addr, ld_data,
    input  fetch_valid, fetch_addr, inst_ready,
    output ld_err, busy, fetch_ready,
    output inst_valid, inst, inst_fault
  );

endinterface

// File: rtl/imem_sram_1r1w.sv
// imem_sram_1r1w: plain 1R1W array, synchronous write and registered read.
// Contents and read data are intentionally not reset.
module imem_sram_1r1w #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: loadable instruction memory with a 1-cycle fetch pipe.
// FSM clears the array after reset, then alternates between RUN and LOAD.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input logic   clk,
  input logic   rst_n,
  imem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state;
  state_e            state_nx;
  logic [IDX_W-1:0]  clr_cnt;
  logic              clr_last;

  dec_t              f_dec;
  dec_t              l_dec;
  logic              accept;
  logic              ld_bad;

  logic              we;
  logic              re;
  logic [IDX_W-1:0]  waddr;
  logic [IDX_W-1:0]  raddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  logic              valid_q;
  logic              ok_q;
  flt_e              flt_q;
  logic              err_q;
  logic              unused_ok;

  assign f_dec = decode(AW_MAX'(bus.fetch_addr), IDX_W);
  assign l_dec = decode(AW_MAX'(bus.ld_addr), IDX_W);

  assign unused_ok = ^{f_dec.idx[AW_MAX-1:IDX_W],
                       l_dec.idx[AW_MAX-1:IDX_W]};

  assign clr_last = (clr_cnt == IDX_W'(DEPTH - 1));
  assign accept   = bus.fetch_valid && bus.fetch_ready;
  assign ld_bad   = (l_dec.fault != FLT_OK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= CLEAR;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (clr_last)
               state_nx = bus.load_en ? LOAD : RUN;
      RUN:   if (bus.load_en)
               state_nx = LOAD;
      LOAD:  if (!bus.load_en)
               state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  always_comb begin
    bus.busy        = 1'b1;
    bus.fetch_ready = 1'b0;
    we              = 1'b0;
    waddr           = clr_cnt;
    wdata           = '0;
    unique case (1'b1)
      (state == CLEAR): begin
        we = 1'b1;
      end
      (state == LOAD): begin
        we    = bus.ld_we && !ld_bad;
        waddr = l_dec.idx[IDX_W-1:0];
        wdata = bus.ld_data;
      end
      (state == RUN): begin
        bus.busy        = 1'b0;
        bus.fetch_ready = !bus.load_en &&
                          (!valid_q || bus.inst_ready);
      end
      default: ;
    endcase
  end

  // Wraps back to 0 after DEPTH-1, so a fresh CLEAR always starts at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clr_cnt <= '0;
    else if (state == CLEAR)
      clr_cnt <= clr_cnt + IDX_W'(1);
  end

  assign re    = accept && (f_dec.fault == FLT_OK);
  assign raddr = f_dec.idx[IDX_W-1:0];

  imem_sram_1r1w #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
      flt_q   <= FLT_OK;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        ok_q    <= (f_dec.fault == FLT_OK);
        flt_q   <= f_dec.fault;
      end else if (bus.inst_ready) begin
        valid_q <= 1'b0;
      end
      err_q <= (state == LOAD) && bus.ld_we && ld_bad;
    end
  end

  // ok_q masks the unreset SRAM output and turns faulted fetches into NOPs.
  assign bus.inst_valid = valid_q;
  assign bus.inst       = ok_q ? rdata : DATA_W'(NOP);
  assign bus.inst_fault = flt_q;
  assign bus.ld_err     = err_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: directed and randomized checks of imem_fetch_unit
// against a word-array reference model kept in the bench.
module tb_imem_fetch_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  imem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_fetch_unit #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0] mem_m [DEPTH];

  function automatic logic [1:0] m_fault(input logic [31:0] a);
    if (a % 4 != 0)
      return 2'b01;
    if (a >= DEPTH * 4)
      return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_inst(input logic [31:0] a);
    if (m_fault(a) != 2'b00)
      return 32'h0;
    return mem_m[a[7:2]];
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)
      return 32'($urandom_range(0, DEPTH - 1)) * 4;
    if (r == 7)
      return 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
    if (r == 8)
      return 32'($urandom_range(DEPTH, 1023)) * 4;
    return 32'($urandom_range(DEPTH, 1023)) * 4 + 32'h2;
  endfunction

  task automatic idle();
    bus.load_en     = 1'b0;
    bus.ld_we       = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.fetch_valid = 1'b0;
    bus.fetch_addr  = '0;
    bus.inst_ready  = 1'b1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++)
      mem_m[i] = 32'h0;
  endtask

  task automatic test_reset();
    int n;
    bit done;
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    #1;
    total++; if (bus.busy !== 1'b1) $display("FAIL rst_busy got=%b exp=1", bus.busy); else pass_cnt++;
    total++; if (bus.fetch_ready !== 1'b0) $display("FAIL rst_fready got=%b exp=0", bus.fetch_ready); else pass_cnt++;
    total++; if (bus.inst_valid !== 1'b0) $display("FAIL rst_ivalid got=%b exp=0", bus.inst_valid); else pass_cnt++;
    total++; if (bus.inst !== 32'h0) $display("FAIL rst_inst got=%h exp=0", bus.inst); else pass_cnt++;
    total++; if (bus.inst_fault !== 2'b00) $display("FAIL rst_fault got=%b exp=00", bus.inst_fault); else pass_cnt++;
    total++; if (bus.ld_err !== 1'b0) $display("FAIL rst_lderr got=%b exp=0", bus.ld_err); else pass_cnt++;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!bus.busy) done = 1;
    end
    total++; if (n != DEPTH) $display("FAIL clear_len got=%0d exp=%0d", n, DEPTH); else pass_cnt++;
    total++; if (bus.fetch_ready !== 1'b1) $display("FAIL run_fready got=%b exp=1", bus.fetch_ready); else pass_cnt++;
  endtask

  task automatic test_clear_fetch();
    bit pend;
    logic [31:0] pa;
    pend = 0;
    pa = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      if (pend) begin
        total++;
        if ({bus.inst_valid, bus.inst, bus.inst_fault} !== {1'b1, m_inst(pa), m_fault(pa)})
          $display("FAIL clr_fetch a=%h got v=%b i=%h f=%b exp i=%h f=%b", pa, bus.inst_valid, bus.inst, bus.inst_fault, m_inst(pa), m_fault(pa));
        else pass_cnt++;
      end
      if (i < DEPTH) begin
        pa = 32'(i * 4);
        bus.fetch_valid = 1'b1;
        bus.fetch_addr  = pa;
        #1;
        total++; if (bus.fetch_ready !== 1'b1) $display("FAIL clr_fready a=%h got=%b exp=1", pa, bus.fetch_ready); else pass_cnt++;
        pend = 1;
      end else begin
        bus.fetch_valid = 1'b0;
      end
    end
    @(negedge clk);
    total++; if (bus.inst_valid !== 1'b0) $display("FAIL clr_drain got=%b exp=0", bus.inst_valid); else pass_cnt++;
  endtask

  task automatic test_load();
    @(negedge clk);
    bus.load_en = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) $display("FAIL ld_busy got=%b exp=1", bus.busy); else pass_cnt++;
    total++; if (bus.fetch_ready !== 1'b0) $display("FAIL ld_fready got=%b exp=0", bus.fetch_ready); else pass_cnt++;
    bus.ld_we   = 1'b1;
    bus.ld_addr = 32'h04;
    bus.ld_data = 32'h1400_0603;
    mem_m[1]    = 32'h1400_0603;
    @(negedge clk);
    bus.ld_addr = 32'h18;
    bus.ld_data = 32'h0001_1022;
    mem_m[6]    = 32'h0001_1022;
    @(negedge clk);
    bus.ld_we   = 1'b0;
    bus.load_en = 1'b0;
    @(negedge clk);
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h04;
    #1;
    total++; if (bus.fetch_ready !== 1'b1) $display("FAIL ld_first_fready got=%b exp=1", bus.fetch_ready); else pass_cnt++;
    @(negedge clk);
    total++; if ({bus.inst_valid, bus.inst} !== {1'b1, 32'h1400_0603}) $display("FAIL ld_rd0 got v=%b i=%h exp i=14000603", bus.inst_valid, bus.inst); else pass_cnt++;
    bus.fetch_addr = 32'h18;
    #1;
    total++; if (bus.fetch_ready !== 1'b1) $display("FAIL ld_b2b_fready got=%b exp=1", bus.fetch_ready); else pass_cnt++;
    @(negedge clk);
    total++; if ({bus.inst_valid, bus.inst} !== {1'b1, 32'h0001_1022}) $display("FAIL ld_rd1 got v=%b i=%h exp i=00011022", bus.inst_valid, bus.inst); else pass_cnt++;
    bus.fetch_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.inst_valid !== 1'b0) $display("FAIL ld_drain got=%b exp=0", bus.inst_valid); else pass_cnt++;
  endtask

  task automatic test_faults();
    logic [31:0] fa [6];
    logic [31:0] ba [2];
    fa[0] = 32'h06;  fa[1] = 32'h100; fa[2] = 32'h103;
    fa[3] = 32'h104; fa[4] = 32'hFFFF_FFFC; fa[5] = 32'h18;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if ({bus.inst_valid, bus.inst, bus.inst_fault} !== {1'b1, m_inst(fa[i-1]), m_fault(fa[i-1])})
          $display("FAIL flt_fetch a=%h got v=%b i=%h f=%b exp i=%h f=%b", fa[i-1], bus.inst_valid, bus.inst, bus.inst_fault, m_inst(fa[i-1]), m_fault(fa[i-1]));
        else pass_cnt++;
      end
      bus.fetch_valid = (i < 6);
      if (i < 6) bus.fetch_addr = fa[i];
    end
    ba[0] = 32'h102;
    ba[1] = 32'h104;
    bus.load_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.ld_we   = 1'b1;
      bus.ld_addr = ba[i];
      bus.ld_data = 32'hBAD0_BAD0;
      @(negedge clk);
      bus.ld_we = 1'b0;
      total++; if (bus.ld_err !== 1'b1) $display("FAIL lderr_pulse a=%h got=%b exp=1", ba[i], bus.ld_err); else pass_cnt++;
      @(negedge clk);
      total++; if (bus.ld_err !== 1'b0) $display("FAIL lderr_once a=%h got=%b exp=0", ba[i], bus.ld_err); else pass_cnt++;
    end
    bus.load_en = 1'b0;
    @(negedge clk);
    bus.ld_we   = 1'b1;
    bus.ld_addr = 32'h08;
    bus.ld_data = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.ld_addr = 32'h102;
    @(negedge clk);
    total++; if (bus.ld_err !== 1'b0) $display("FAIL run_ldwe_err got=%b exp=0", bus.ld_err); else pass_cnt++;
    bus.ld_we = 1'b0;
    fa[0] = 32'h00; fa[1] = 32'h04; fa[2] = 32'h08;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if ({bus.inst_valid, bus.inst} !== {1'b1, m_inst(fa[i-1])})
          $display("FAIL nowrite a=%h got v=%b i=%h exp i=%h", fa[i-1], bus.inst_valid, bus.inst, m_inst(fa[i-1]));
        else pass_cnt++;
      end
      bus.fetch_valid = (i < 3);
      if (i < 3) bus.fetch_addr = fa[i];
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    e = m_inst(32'h04);
    @(negedge clk);
    bus.inst_ready  = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h04;
    #1;
    total++; if (bus.fetch_ready !== 1'b1) $display("FAIL bp_accept got=%b exp=1", bus.fetch_ready); else pass_cnt++;
    @(negedge clk);
    bus.fetch_addr = 32'h18;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if ({bus.inst_valid, bus.inst, bus.inst_fault, bus.fetch_ready} !== {1'b1, e, 2'b00, 1'b0})
        $display("FAIL bp_hold k=%0d got v=%b i=%h f=%b r=%b exp v=1 i=%h f=00 r=0", k, bus.inst_valid, bus.inst, bus.inst_fault, bus.fetch_ready, e);
      else pass_cnt++;
      @(negedge clk);
    end
    bus.inst_ready = 1'b1;
    #1;
    total++; if (bus.fetch_ready !== 1'b1) $display("FAIL bp_release got=%b exp=1", bus.fetch_ready); else pass_cnt++;
    @(negedge clk);
    total++; if ({bus.inst_valid, bus.inst} !== {1'b1, m_inst(32'h18)}) $display("FAIL bp_next got v=%b i=%h exp i=%h", bus.inst_valid, bus.inst, m_inst(32'h18)); else pass_cnt++;
    bus.fetch_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_pending();
    @(negedge clk);
    bus.inst_ready  = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h18;
    @(negedge clk);
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h00;
    bus.load_en     = 1'b1;
    bus.inst_ready  = 1'b1;
    #1;
    total++; if (bus.fetch_ready !== 1'b0) $display("FAIL lp_fready got=%b exp=0", bus.fetch_ready); else pass_cnt++;
    bus.inst_ready  = 1'b0;
    bus.fetch_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.inst_valid, bus.inst} !== {1'b1, 1'b1, m_inst(32'h18)})
      $display("FAIL lp_pending got b=%b v=%b i=%h exp b=1 v=1 i=%h", bus.busy, bus.inst_valid, bus.inst, m_inst(32'h18));
    else pass_cnt++;
    bus.inst_ready = 1'b1;
    bus.ld_we      = 1'b1;
    bus.ld_addr    = 32'h08;
    bus.ld_data    = 32'hCAFE_F00D;
    mem_m[2]       = 32'hCAFE_F00D;
    @(negedge clk);
    total++; if ({bus.busy, bus.inst_valid} !== 2'b10) $display("FAIL lp_drain got b=%b v=%b exp b=1 v=0", bus.busy, bus.inst_valid); else pass_cnt++;
    bus.ld_we   = 1'b0;
    bus.load_en = 1'b0;
    @(negedge clk);
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h08;
    @(negedge clk);
    total++; if ({bus.inst_valid, bus.inst} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL lp_ldwe got v=%b i=%h exp i=cafef00d", bus.inst_valid, bus.inst); else pass_cnt++;
    bus.fetch_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    bit done;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({bus.busy, bus.fetch_ready, bus.inst_valid} !== 3'b100) $display("FAIL midclr_rst got b=%b r=%b v=%b exp 100", bus.busy, bus.fetch_ready, bus.inst_valid); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); n++;
      @(negedge clk); if (!bus.busy) done = 1;
    end
    total++; if (n != DEPTH) $display("FAIL midclr_len got=%0d exp=%0d", n, DEPTH); else pass_cnt++;
    bus.load_en = 1'b1;
    @(negedge clk);
    bus.ld_we   = 1'b1;
    bus.ld_addr = 32'h10;
    bus.ld_data = 32'h1234_5678;
    @(negedge clk);
    bus.ld_we   = 1'b0;
    bus.load_en = 1'b0;
    @(negedge clk);
    bus.inst_ready  = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h10;
    @(negedge clk);
    bus.fetch_valid = 1'b0;
    bus.load_en     = 1'b1;
    @(negedge clk);
    total++; if ({bus.busy, bus.inst_valid, bus.inst} !== {2'b11, 32'h1234_5678}) $display("FAIL midld_pre got b=%b v=%b i=%h exp b=1 v=1 i=12345678", bus.busy, bus.inst_valid, bus.inst); else pass_cnt++;
    bus.ld_we   = 1'b1;
    bus.ld_addr = 32'h14;
    bus.ld_data = 32'h5555_AAAA;
    rst_n       = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.fetch_ready, bus.inst_valid, bus.inst, bus.inst_fault, bus.ld_err} !== {3'b100, 32'h0, 2'b00, 1'b0})
      $display("FAIL midld_rst got b=%b r=%b v=%b i=%h f=%b e=%b exp b=1 r=0 v=0 i=0 f=00 e=0", bus.busy, bus.fetch_ready, bus.inst_valid, bus.inst, bus.inst_fault, bus.ld_err);
    else pass_cnt++;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); n++;
      @(negedge clk); if (!bus.busy) done = 1;
    end
    total++; if (n != DEPTH) $display("FAIL midld_len got=%0d exp=%0d", n, DEPTH); else pass_cnt++;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h10;
    @(negedge clk);
    bus.fetch_addr  = 32'h14;
    total++; if ({bus.inst_valid, bus.inst} !== {1'b1, 32'h0}) $display("FAIL midld_clr10 got v=%b i=%h exp i=0", bus.inst_valid, bus.inst); else pass_cnt++;
    @(negedge clk);
    bus.fetch_valid = 1'b0;
    total++; if ({bus.inst_valid, bus.inst} !== {1'b1, 32'h0}) $display("FAIL midld_clr14 got v=%b i=%h exp i=0", bus.inst_valid, bus.inst); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          exp_err;
    bit          we;
    bit          exp_rdy;
    logic [31:0] a;
    logic [31:0] d;
    bit          pv;
    logic [31:0] pi;
    logic [1:0]  pf;
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    bus.load_en = 1'b1;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DEPTH) @(negedge clk);
    total++; if ({bus.busy, bus.fetch_ready} !== 2'b10) $display("FAIL rnd_clr2load got b=%b r=%b exp b=1 r=0", bus.busy, bus.fetch_ready); else pass_cnt++;
    exp_err = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++; if (bus.ld_err !== exp_err) $display("FAIL rnd_lderr i=%0d got=%b exp=%b", i, bus.ld_err, exp_err); else pass_cnt++;
      a  = rnd_addr();
      d  = $urandom;
      we = ($urandom_range(0, 3) != 0);
      bus.ld_we   = we;
      bus.ld_addr = a;
      bus.ld_data = d;
      if (we && m_fault(a) == 2'b00) mem_m[a[7:2]] = d;
      exp_err = we && (m_fault(a) != 2'b00);
    end
    @(negedge clk);
    total++; if (bus.ld_err !== exp_err) $display("FAIL rnd_lderr_last got=%b exp=%b", bus.ld_err, exp_err); else pass_cnt++;
    bus.ld_we   = 1'b0;
    bus.load_en = 1'b0;
    pv = 0; pi = 0; pf = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      total++; if (bus.inst_valid !== pv) $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, bus.inst_valid, pv); else pass_cnt++;
      if (pv) begin
        total++;
        if ({bus.inst, bus.inst_fault} !== {pi, pf})
          $display("FAIL rnd_resp i=%0d got i=%h f=%b exp i=%h f=%b", i, bus.inst, bus.inst_fault, pi, pf);
        else pass_cnt++;
      end
      a = rnd_addr();
      bus.inst_ready  = ($urandom_range(0, 3) != 0);
      bus.fetch_valid = ($urandom_range(0, 3) != 0);
      bus.fetch_addr  = a;
      #1;
      exp_rdy = !pv || bus.inst_ready;
      total++; if (bus.fetch_ready !== exp_rdy) $display("FAIL rnd_fready i=%0d got=%b exp=%b", i, bus.fetch_ready, exp_rdy); else pass_cnt++;
      if (bus.fetch_valid && exp_rdy) begin
        pv = 1; pi = m_inst(a); pf = m_fault(a);
      end else if (bus.inst_ready) begin
        pv = 0;
      end
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.inst_valid !== 1'b0) $display("FAIL rnd_drain got=%b exp=0", bus.inst_valid); else pass_cnt++;
  endtask

  initial begin
    idle();
    test_reset();
    test_clear_fetch();
    test_load();
    test_faults();
    test_backpressure();
    test_load_pending();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
